// File: rtl/uart_rx_top.sv
// UART 8N1 receiver: oversampled start/data/stop framing, LSB-first deserialisation,
// one-cycle done pulse and an absorbing error state on a bad stop bit.

module uart_rx_fsm #(
    parameter int unsigned CLKS_PER_BIT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic soft_rst_i,
    input  logic rx_i,
    output logic shift_o,
    output logic commit_o,
    output logic busy_o,
    output logic done_o,
    output logic error_o
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] MID  = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        DONE  = 3'd4,
        ERROR = 3'd5
    } state_t;

    state_t           cs;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       idx_q;
    logic             stop_q;

    logic mid_c;
    logic last_c;
    logic stop_bit_c;

    assign mid_c  = (cnt_q == MID);
    assign last_c = (cnt_q == LAST);
    // When the mid point coincides with the last cycle the stop bit is taken straight from the line.
    assign stop_bit_c = mid_c ? rx_i : stop_q;

    assign shift_o  = (cs == DATA) && mid_c;
    assign commit_o = (cs == STOP) && last_c && stop_bit_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs      <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            error_o <= 1'b0;
        end else if (soft_rst_i) begin
            cs      <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            error_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (cs)
                IDLE: begin
                    if (!rx_i) begin
                        cs     <= START;
                        cnt_q  <= CNT_W'(1);
                        busy_o <= 1'b1;
                    end
                end
                START: begin
                    if (mid_c && rx_i) begin
                        cs     <= IDLE;
                        cnt_q  <= '0;
                        busy_o <= 1'b0;
                    end else if (last_c) begin
                        cs    <= DATA;
                        cnt_q <= '0;
                        idx_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (last_c) begin
                        cnt_q <= '0;
                        idx_q <= idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            cs <= STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (mid_c) begin
                        stop_q <= rx_i;
                    end
                    if (last_c) begin
                        cnt_q  <= '0;
                        busy_o <= 1'b0;
                        if (stop_bit_c) begin
                            cs     <= DONE;
                            done_o <= 1'b1;
                        end else begin
                            cs      <= ERROR;
                            error_o <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    // A low line here is already cycle 0 of the next start bit.
                    if (!rx_i) begin
                        cs     <= START;
                        cnt_q  <= CNT_W'(1);
                        busy_o <= 1'b1;
                    end else begin
                        cs <= IDLE;
                    end
                end
                ERROR: begin
                    cs <= ERROR;
                end
                default: begin
                    cs      <= IDLE;
                    cnt_q   <= '0;
                    busy_o  <= 1'b0;
                    error_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

module uart_rx_top #(
    parameter int unsigned CLKS_PER_BIT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       soft_rst,
    input  logic       rx_data_in,
    output logic       rx_busy,
    output logic       rx_done,
    output logic       error,
    output logic [7:0] rx_data_out
);

    logic       shift_c;
    logic       commit_c;
    logic [7:0] shreg_q;

    uart_rx_fsm #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) FSM (
        .clk        (clk),
        .rst        (rst),
        .soft_rst_i (soft_rst),
        .rx_i       (rx_data_in),
        .shift_o    (shift_c),
        .commit_o   (commit_c),
        .busy_o     (rx_busy),
        .done_o     (rx_done),
        .error_o    (error)
    );

    // Right shift: after eight samples the first bit received sits in bit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q     <= 8'h00;
            rx_data_out <= 8'h00;
        end else if (soft_rst) begin
            shreg_q     <= 8'h00;
            rx_data_out <= 8'h00;
        end else begin
            if (shift_c) begin
                shreg_q <= {rx_data_in, shreg_q[7:1]};
            end
            if (commit_c) begin
                rx_data_out <= shreg_q;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_top.sv
// Self-checking bench for uart_rx_top: reset behaviour, exhaustive and random frames,
// glitch rejection, error absorption and recovery.

module tb_uart_rx_top;

    localparam int unsigned CPB = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       soft_rst;
    logic       rx;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] dout;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: the last byte a good frame delivered since the last reset.
    logic [7:0] exp_data = 8'h00;

    uart_rx_top #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .soft_rst    (soft_rst),
        .rx_data_in  (rx),
        .rx_busy     (busy),
        .rx_done     (done),
        .error       (err),
        .rx_data_out (dout)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one frame, bit 0 first; each bit holds the line for CPB clocks.
    task automatic send_frame(input logic [9:0] f);
        for (int b = 0; b < 10; b++) begin
            rx = f[b];
            tick(CPB);
            if (b < 9) check("busy_in_frame", 32'(busy), 32'd1);
            if (b == 0) check("done_low_in_frame", 32'(done), 32'd0);
        end
    endtask

    // Expected outcome of a complete frame: good stop delivers the data bits, bad stop locks ERROR.
    task automatic expect_frame(input logic [9:0] f, input string tag);
        if (f[9]) begin
            exp_data = f[8:1];
            check({tag, "_done"},  32'(done), 32'd1);
            check({tag, "_error"}, 32'(err),  32'd0);
        end else begin
            check({tag, "_done"},  32'(done), 32'd0);
            check({tag, "_error"}, 32'(err),  32'd1);
        end
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_data"}, 32'(dout), 32'(exp_data));
    endtask

    task automatic pulse_soft_rst();
        soft_rst = 1'b1;
        tick(1);
        soft_rst = 1'b0;
        exp_data = 8'h00;
        check("srst_error", 32'(err), 32'd0);
        check("srst_state", 32'(dut.FSM.cs), 32'd0);
        check("srst_data", 32'(dout), 32'd0);
    endtask

    initial begin
        logic [9:0] f;
        logic [7:0] d;
        logic       stop;
        int         gap;

        rst      = 1'b1;
        soft_rst = 1'b0;
        rx       = 1'b0;

        for (int k = 0; k < 36; k++) begin
            tick(1);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
        end
        check("rst_data", 32'(dout), 32'd0);
        check("rst_error", 32'(err), 32'd0);

        rst      = 1'b0;
        soft_rst = 1'b1;
        for (int k = 0; k < 36; k++) begin
            tick(1);
            check("srst_hold_state", 32'(dut.FSM.cs), 32'd0);
        end

        soft_rst = 1'b0;
        rx       = 1'b1;
        tick(5);
        check("idle_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 256; i++) begin
            f = {1'b1, 8'(i), 1'b0};
            send_frame(f);
            expect_frame(f, "b2b");
        end
        rx = 1'b1;
        tick(2);
        check("b2b_done_pulse", 32'(done), 32'd0);

        // Start-bit glitch shorter than the mid sample is rejected.
        rx = 1'b0;
        tick(1);
        rx = 1'b1;
        tick(1);
        check("glitch_state", 32'(dut.FSM.cs), 32'd0);
        tick(CPB * 10);
        check("glitch_busy", 32'(busy), 32'd0);
        check("glitch_done", 32'(done), 32'd0);
        check("glitch_data", 32'(dout), 32'(exp_data));

        // Random frames with random idle gaps and occasional bad stop bits.
        for (int n = 0; n < 60; n++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 7) != 0);
            gap  = $urandom_range(0, 4);
            rx   = 1'b1;
            if (gap > 0) tick(gap);
            f = {stop, d, 1'b0};
            send_frame(f);
            expect_frame(f, "rnd");
            if (!stop) begin
                rx = 1'b0;
                tick(CPB * 4);
                check("rnd_err_hold", 32'(err), 32'd1);
                rx = 1'b1;
                pulse_soft_rst();
            end
        end

        // Hard reset mid-frame discards the frame and clears the output byte.
        rx = 1'b1;
        tick(2);
        rx = 1'b0;
        tick(CPB * 4);
        check("midrst_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        exp_data = 8'h00;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_data", 32'(dout), 32'd0);
        rx = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
        f = {1'b1, 8'h5C, 1'b0};
        send_frame(f);
        expect_frame(f, "postrst");

        // Soft reset mid-frame.
        rx = 1'b0;
        tick(CPB * 5);
        rx = 1'b1;
        pulse_soft_rst();
        check("midsrst_busy", 32'(busy), 32'd0);
        tick(2);

        f = {1'b0, 8'h33, 1'b0};
        send_frame(f);
        expect_frame(f, "badstop");

        for (int k = 0; k < 10; k++) begin
            rx = k[0];
            tick(1);
            check("err_toggle_error", 32'(err), 32'd1);
            check("err_toggle_busy", 32'(busy), 32'd0);
        end
        rx = 1'b0;
        for (int k = 0; k < 30; k++) begin
            tick(1);
            check("err_low_error", 32'(err), 32'd1);
            check("err_low_busy", 32'(busy), 32'd0);
        end

        rx = 1'b1;
        pulse_soft_rst();
        tick(2);
        f = {1'b1, 8'hA5, 1'b0};
        send_frame(f);
        expect_frame(f, "recover");
        rx = 1'b1;
        tick(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
